// File: rtl/multdiv_unit_pkg.sv
// Shared processor definitions for the iterative multiply/divide unit and the
// execute-stage stall controller.
package multdiv_unit_pkg;

  // Iterations per multiply or divide (one Booth step / quotient bit per cycle)
  localparam int unsigned MULDIV_ITER = 32;

  // ALU op field values that select the mult/div unit (opcode 0)
  localparam logic [4:0] ALUOP_MULT = 5'd6;
  localparam logic [4:0] ALUOP_DIV  = 5'd7;

  // Sequencer states; the encoding is shared with the stall logic
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One restoring-division step on unsigned magnitudes.
// The pair is {remainder, quotient}; the dividend enters through the quotient
// half and is shifted into the remainder one bit per step.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_rq,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic [2*WIDTH-1:0] o_rq
);

  logic [2*WIDTH:0] w_shift;
  logic [WIDTH:0]   w_rem;
  logic [WIDTH-1:0] w_rem_sub;
  logic             w_ge;

  // Shift the pair left, then subtract the divisor if it fits and set the quotient bit
  always_comb begin
    w_shift   = {i_rq, 1'b0};
    w_rem     = w_shift[2*WIDTH:WIDTH];
    w_ge      = (w_rem >= {1'b0, i_divisor});
    // The true difference is below the divisor, so it always fits in WIDTH bits
    w_rem_sub = w_rem[WIDTH-1:0] - i_divisor;
    o_rq      = w_shift[2*WIDTH-1:0];
    if (w_ge) begin
      o_rq = {w_rem_sub, w_shift[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier (radix-2 Booth) / divider (restoring) for the
// execute stage. One operation in flight; a start in any state restarts.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = MULDIV_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CW = $clog2(ITER + 1);

  md_state_e        r_state, w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_iter_end;
  logic             w_start;
  logic             w_finish;

  // Booth datapath: {upper, multiplier, extra bit}
  logic [2*WIDTH:0] r_prod;
  logic [2*WIDTH:0] w_prod_next;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH:0]   w_booth_sum;

  // Divide datapath
  logic [2*WIDTH-1:0] r_rq;
  logic [2*WIDTH-1:0] w_rq_next;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_qneg;
  logic               r_bzero;
  logic               r_ovf;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH-1:0]   w_quo;

  // Result registers
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic [WIDTH-1:0] w_res_next;
  logic             w_exc_next;

  assign w_start    = ctrl_MULT | ctrl_DIV;
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_iter_end = (w_cnt_inc == CW'(ITER));
  assign w_finish   = ((r_state == MD_MUL) || (r_state == MD_DIV)) && w_iter_end && !w_start;

  // Next-state logic; a start overrides every transition, multiply has priority
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      MD_MUL, MD_DIV: if (w_iter_end) w_state_next = MD_DONE;
      MD_DONE:        w_state_next = MD_IDLE;
      default:        w_state_next = r_state;
    endcase
    if (ctrl_MULT) begin
      w_state_next = MD_MUL;
    end else if (ctrl_DIV) begin
      w_state_next = MD_DIV;
    end
  end

  // State register and iteration counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_cnt <= '0;
      end else if ((r_state == MD_MUL) || (r_state == MD_DIV)) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  // Booth step: add/subtract the multiplicand on 01/10, then arithmetic shift right.
  // The sum is one bit wider than the upper half so a -2^(W-1) multiplicand keeps its sign.
  always_comb begin
    w_booth_sum = {r_prod[2*WIDTH], r_prod[2*WIDTH:WIDTH+1]};
    unique case (r_prod[1:0])
      2'b01:   w_booth_sum = {r_prod[2*WIDTH], r_prod[2*WIDTH:WIDTH+1]} + {r_mcand[WIDTH-1], r_mcand};
      2'b10:   w_booth_sum = {r_prod[2*WIDTH], r_prod[2*WIDTH:WIDTH+1]} - {r_mcand[WIDTH-1], r_mcand};
      default: w_booth_sum = {r_prod[2*WIDTH], r_prod[2*WIDTH:WIDTH+1]};
    endcase
    w_prod_next = {w_booth_sum, r_prod[WIDTH:1]};
  end

  // Operand magnitudes for the divider (0x80000000 maps to itself as unsigned)
  always_comb begin
    w_absA = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    w_absB = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rq      (r_rq),
    .i_divisor (r_divisor),
    .o_rq      (w_rq_next)
  );

  assign w_quo = w_rq_next[WIDTH-1:0];

  // Final result from the last iteration, sign/exception fix-up for divide
  always_comb begin
    w_res_next = '0;
    w_exc_next = 1'b0;
    if (r_state == MD_MUL) begin
      w_res_next = w_prod_next[WIDTH:1];
      w_exc_next = !((&w_prod_next[2*WIDTH:WIDTH]) || !(|w_prod_next[2*WIDTH:WIDTH]));
    end else if (r_bzero) begin
      w_res_next = '0;
      w_exc_next = 1'b1;
    end else begin
      w_res_next = r_qneg ? (~w_quo + WIDTH'(1)) : w_quo;
      w_exc_next = r_ovf;
    end
  end

  // Operand capture on start, one iteration per cycle while busy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prod    <= '0;
      r_mcand   <= '0;
      r_rq      <= '0;
      r_divisor <= '0;
      r_qneg    <= 1'b0;
      r_bzero   <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (ctrl_MULT) begin
      r_prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
      r_mcand <= data_operandA;
    end else if (ctrl_DIV) begin
      r_rq      <= {{WIDTH{1'b0}}, w_absA};
      r_divisor <= w_absB;
      r_qneg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_bzero   <= (data_operandB == '0);
      r_ovf     <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
    end else if (r_state == MD_MUL) begin
      r_prod <= w_prod_next;
    end else if (r_state == MD_DIV) begin
      r_rq <= w_rq_next;
    end
  end

  // Result/exception registers, loaded on the edge entering DONE and held otherwise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_finish) begin
      r_result <= w_res_next;
      r_exc    <= w_exc_next;
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == MD_DONE);
  assign busy           = (r_state == MD_MUL) || (r_state == MD_DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: stimulus pushes hand-computed results with
// their expected RDY cycle, a negedge monitor pops and compares on each RDY.
module tb_multdiv_unit;

  typedef struct {
    int          cyc;
    logic [31:0] res;
    logic        exc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t q[$];
  exp_t e;

  multdiv_unit #(
    .WIDTH (32),
    .ITER  (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RDY must match the oldest expectation, at exactly its cycle
  always @(negedge clock) begin
    if (reset) begin
      if (q.size() > 0 && cyc > q[0].cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL rdy_missing: no RDY by cycle %0d, expected at %0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (data_resultRDY) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rdy_unexpected: RDY at cycle %0d with nothing outstanding", cyc);
        end else begin
          e = q.pop_front();
          check("rdy_cycle", 32'(cyc), 32'(e.cyc));
          check("result", data_result, e.res);
          check("exception", {31'd0, data_exception}, {31'd0, e.exc});
          check("busy_in_rdy", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  // Drive one start pulse; the start edge is the posedge following the drive
  task automatic start_op(input bit sync, input logic mul, input logic div,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit expect_it, input logic [31:0] res, input logic exc);
    exp_t x;
    if (sync) @(negedge clock);
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    if (expect_it) begin
      x.cyc = cyc + 1 + 32;
      x.res = res;
      x.exc = exc;
      q.push_back(x);
    end
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results still outstanding", q.size());
      q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("reset_result", data_result, 32'd0);
    check("reset_exc", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // 7 * -3 = -21
    start_op(1, 1, 0, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 1'b0);
    repeat (5) @(negedge clock);
    check("busy_mid_op", {31'd0, busy}, 32'd1);
    check("rdy_mid_op", {31'd0, data_resultRDY}, 32'd0);
    wait_drain();

    // 2^16 * 2^16 = 2^32: low word 0, overflow
    start_op(1, 1, 0, 32'h0001_0000, 32'h0001_0000, 1, 32'h0000_0000, 1'b1);
    wait_drain();
    // -2^31 * -1 = 2^31: overflow
    start_op(1, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b1);
    wait_drain();
    // -4 * -5 = 20
    start_op(1, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 1, 32'd20, 1'b0);
    wait_drain();

    // -17 / 5 = -3 (truncation toward zero)
    start_op(1, 0, 1, 32'hFFFF_FFEF, 32'd5, 1, 32'hFFFF_FFFD, 1'b0);
    wait_drain();
    // -7 / -2 = 3
    start_op(1, 0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1, 32'd3, 1'b0);
    wait_drain();
    // divide by zero
    start_op(1, 0, 1, 32'd123, 32'd0, 1, 32'd0, 1'b1);
    wait_drain();
    // -2^31 / -1 overflows
    start_op(1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b1);
    wait_drain();

    // Restart: divide sampled 10 edges into a multiply; only the divide completes
    start_op(1, 1, 0, 32'd100, 32'd7, 0, 32'd0, 1'b0);
    repeat (8) @(negedge clock);
    start_op(1, 0, 1, 32'd100, 32'd7, 1, 32'd14, 1'b0);
    wait_drain();

    // Both start lines: multiply wins (6*5=30, not 6/5=1)
    start_op(1, 1, 1, 32'd6, 32'd5, 1, 32'd30, 1'b0);
    wait_drain();

    // Asynchronous reset 15 cycles into a divide
    start_op(1, 0, 1, 32'd1000, 32'd3, 0, 32'd0, 1'b0);
    repeat (14) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("async_rst_result", data_result, 32'd0);
    check("async_rst_exc", {31'd0, data_exception}, 32'd0);
    check("async_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    start_op(1, 1, 0, 32'd9, 32'd9, 1, 32'd81, 1'b0);
    wait_drain();

    // Back-to-back: second start driven while the first RDY is high
    start_op(1, 0, 1, 32'd100, 32'hFFFF_FFF9, 1, 32'hFFFF_FFF2, 1'b0);
    repeat (32) @(negedge clock);
    check("b2b_rdy_at_drive", {31'd0, data_resultRDY}, 32'd1);
    start_op(0, 1, 0, 32'h4000_0000, 32'd3, 1, 32'hC000_0000, 1'b1);
    repeat (10) @(negedge clock);
    check("b2b_held_result", data_result, 32'hFFFF_FFF2);
    check("b2b_held_exc", {31'd0, data_exception}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_drain();

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
